// File: rtl/tbird_light_seq_if.sv
// Signal bundle between the clock divider/request logic and the tail-light
// sequencer. The master side drives the divided enable and the turn/hazard
// requests; the slave (the sequencer) returns the step pulse and lamp pattern.
interface tbird_light_seq_if;
    logic       clk_en;
    logic       left;
    logic       right;
    logic       hazard;
    logic       step;
    logic [2:0] l_lamp;
    logic [2:0] r_lamp;

    modport master (
        output clk_en, left, right, hazard,
        input  step, l_lamp, r_lamp
    );

    modport slave (
        input  clk_en, left, right, hazard,
        output step, l_lamp, r_lamp
    );
endinterface

// File: rtl/tbird_light_seq.sv
// Thunderbird tail-light sequencer.
// Converts each rising edge of the divided enable into a one-cycle step pulse
// and advances a Moore FSM on that pulse. The FSM drives the left/right lamp
// patterns for the turn signals and the hazard flasher.
module tbird_light_seq #(
    parameter bit IDLE_ON = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    tbird_light_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        L1   = 3'd1,
        L2   = 3'd2,
        L3   = 3'd3,
        R1   = 3'd4,
        R2   = 3'd5,
        R3   = 3'd6,
        HAZ  = 3'd7
    } state_t;

    localparam logic [2:0] IDLE_PAT = IDLE_ON ? 3'b111 : 3'b000;

    state_t     state;
    state_t     state_next;
    logic       clk_en_q;
    logic       step;
    logic       req_h;
    logic       req_l;
    logic       req_r;
    logic [2:0] l_lamp;
    logic [2:0] r_lamp;

    // Delay the divided enable by one cycle for rising-edge detection.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // Held at 1 so an enable already high when reset releases is not
            // mistaken for a fresh rising edge.
            clk_en_q <= 1'b1;
        end else begin
            clk_en_q <= bus.clk_en;
        end
    end

    assign step = bus.clk_en & ~clk_en_q;

    // Requests decoded by priority: hazard (or both turns) beats a single turn.
    assign req_h = bus.hazard | (bus.left & bus.right);
    assign req_l = bus.left  & ~bus.right & ~bus.hazard;
    assign req_r = bus.right & ~bus.left  & ~bus.hazard;

    // State register: advances only on step cycles, otherwise holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else if (step) begin
            state <= state_next;
        end
    end

    // Next-state logic; started sequences always run to completion.
    always_comb begin
        // NOTE: assigning a default before the case keeps this purely
        // combinational; a path that leaves it unassigned would infer a latch.
        state_next = IDLE;
        case (state)
            IDLE: begin
                if (req_h) begin
                    state_next = HAZ;
                end else if (req_l) begin
                    state_next = L1;
                end else if (req_r) begin
                    state_next = R1;
                end else begin
                    state_next = IDLE;
                end
            end
            L1:      state_next = L2;
            L2:      state_next = L3;
            L3:      state_next = IDLE;
            R1:      state_next = R2;
            R2:      state_next = R3;
            R3:      state_next = IDLE;
            HAZ:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore lamp decode from the current state only.
    always_comb begin
        l_lamp = 3'b000;
        r_lamp = 3'b000;
        case (state)
            IDLE: begin
                l_lamp = IDLE_PAT;
                r_lamp = IDLE_PAT;
            end
            L1:  l_lamp = 3'b001;
            L2:  l_lamp = 3'b011;
            L3:  l_lamp = 3'b111;
            R1:  r_lamp = 3'b001;
            R2:  r_lamp = 3'b011;
            R3:  r_lamp = 3'b111;
            HAZ: begin
                l_lamp = 3'b111;
                r_lamp = 3'b111;
            end
            default: begin
                l_lamp = IDLE_PAT;
                r_lamp = IDLE_PAT;
            end
        endcase
    end

    assign bus.step   = step;
    assign bus.l_lamp = l_lamp;
    assign bus.r_lamp = r_lamp;

endmodule

// File: tb/tb_tbird_light_seq.sv
// Directed bench for tbird_light_seq. Two instances share stimulus: one with
// lamps dark in IDLE, one built with IDLE_ON=1 (parking lights).
module tb_tbird_light_seq;

    logic clk;
    logic rst;
    logic clk_en;
    logic left;
    logic right;
    logic hazard;

    int checks   = 0;
    int failures = 0;

    tbird_light_seq_if bus0 ();
    tbird_light_seq_if bus1 ();

    assign bus0.clk_en = clk_en;
    assign bus0.left   = left;
    assign bus0.right  = right;
    assign bus0.hazard = hazard;
    assign bus1.clk_en = clk_en;
    assign bus1.left   = left;
    assign bus1.right  = right;
    assign bus1.hazard = hazard;

    tbird_light_seq #(.IDLE_ON(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    tbird_light_seq #(.IDLE_ON(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls the sequence of tests.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Drop clk_en for low_n cycles, then hold it high for high_n cycles.
    // Entered and left just after a posedge. Reports how many step pulses
    // dut0 produced and the lamp values seen during the step cycle.
    task automatic drive_step(input int low_n, input int high_n,
                              output int steps_seen,
                              output logic [2:0] l_at_step,
                              output logic [2:0] r_at_step);
        steps_seen = 0;
        l_at_step  = 3'bxxx;
        r_at_step  = 3'bxxx;
        clk_en     = 1'b0;
        for (int i = 0; i < low_n + high_n; i++) begin
            if (i == low_n) clk_en = 1'b1;
            @(negedge clk);
            if (bus0.step === 1'b1) begin
                steps_seen++;
                l_at_step = bus0.l_lamp;
                r_at_step = bus0.r_lamp;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int n;
        logic [2:0] la;
        logic [2:0] ra;
        rst    = 1'b0;
        clk_en = 1'b1;
        left   = 1'b0;
        right  = 1'b0;
        hazard = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus0.l_lamp !== 3'b000 || bus0.r_lamp !== 3'b000) begin
            failures++; $display("FAIL reset_lamps: got l=%b r=%b, expected l=000 r=000", bus0.l_lamp, bus0.r_lamp);
        end
        checks++; if (bus1.l_lamp !== 3'b111 || bus1.r_lamp !== 3'b111) begin
            failures++; $display("FAIL reset_lamps_idle_on: got l=%b r=%b, expected l=111 r=111", bus1.l_lamp, bus1.r_lamp);
        end
        checks++; if (bus0.step !== 1'b0) begin
            failures++; $display("FAIL reset_step: got %b, expected 0", bus0.step);
        end
        rst = 1'b1;
        // clk_en stays high: no step may appear.
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus0.step !== 1'b0) n++;
            @(posedge clk);
            #1;
        end
        checks++; if (n !== 0) begin
            failures++; $display("FAIL no_spurious_step: got %0d step cycles, expected 0", n);
        end
        checks++; if (bus0.l_lamp !== 3'b000 || bus0.r_lamp !== 3'b000) begin
            failures++; $display("FAIL idle_after_release: got l=%b r=%b, expected l=000 r=000", bus0.l_lamp, bus0.r_lamp);
        end
        // One clean 0->1 edge, then held high: exactly one step.
        drive_step(4, 6, n, la, ra);
        checks++; if (n !== 1) begin
            failures++; $display("FAIL single_step: got %0d step cycles, expected 1", n);
        end
        // A 1->0 edge alone must not step.
        clk_en = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus0.step !== 1'b0) n++;
            @(posedge clk);
            #1;
        end
        clk_en = 1'b1;
        @(negedge clk);
        checks++; if (n !== 0 || bus0.step !== 1'b1) begin
            failures++; $display("FAIL falling_edge: got %0d steps while low and step=%b on rise, expected 0 and 1", n, bus0.step);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_left();
        logic [2:0] exp_l [4];
        logic [2:0] prev;
        logic [2:0] la;
        logic [2:0] ra;
        int n;
        exp_l[0] = 3'b001;
        exp_l[1] = 3'b011;
        exp_l[2] = 3'b111;
        exp_l[3] = 3'b000;
        prev = 3'b000;
        left = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive_step(8, 8, n, la, ra);
            checks++; if (n !== 1) begin
                failures++; $display("FAIL left_step_count[%0d]: got %0d, expected 1", k, n);
            end
            checks++; if (la !== prev) begin
                failures++; $display("FAIL left_latency[%0d]: got l=%b during step cycle, expected %b", k, la, prev);
            end
            checks++; if (bus0.l_lamp !== exp_l[k % 4] || bus0.r_lamp !== 3'b000) begin
                failures++; $display("FAIL left_seq[%0d]: got l=%b r=%b, expected l=%b r=000", k, bus0.l_lamp, bus0.r_lamp, exp_l[k % 4]);
            end
            prev = exp_l[k % 4];
        end
        left = 1'b0;
    endtask

    task automatic test_sampling();
        int n;
        logic [2:0] la;
        logic [2:0] ra;
        // Hazard pulses between steps and is gone by the step: ignored.
        hazard = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        hazard = 1'b0;
        drive_step(3, 3, n, la, ra);
        checks++; if (bus0.l_lamp !== 3'b000 || bus0.r_lamp !== 3'b000) begin
            failures++; $display("FAIL ignore_between_steps: got l=%b r=%b, expected l=000 r=000", bus0.l_lamp, bus0.r_lamp);
        end
    endtask

    task automatic test_mid_change();
        logic [2:0] exp_l [6];
        logic [2:0] exp_r [6];
        logic [2:0] la;
        logic [2:0] ra;
        int n;
        exp_l[0] = 3'b000; exp_r[0] = 3'b001;
        exp_l[1] = 3'b000; exp_r[1] = 3'b011;
        exp_l[2] = 3'b000; exp_r[2] = 3'b111;
        exp_l[3] = 3'b000; exp_r[3] = 3'b000;
        exp_l[4] = 3'b111; exp_r[4] = 3'b111;
        exp_l[5] = 3'b000; exp_r[5] = 3'b000;
        right = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 2) begin
                right  = 1'b0;
                hazard = 1'b1;
            end
            if (k == 5) hazard = 1'b0;
            drive_step(4, 4, n, la, ra);
            checks++; if (bus0.l_lamp !== exp_l[k] || bus0.r_lamp !== exp_r[k]) begin
                failures++; $display("FAIL mid_change[%0d]: got l=%b r=%b, expected l=%b r=%b", k, bus0.l_lamp, bus0.r_lamp, exp_l[k], exp_r[k]);
            end
        end
    endtask

    task automatic test_left_right();
        logic [2:0] exp;
        logic [2:0] la;
        logic [2:0] ra;
        int n;
        left  = 1'b1;
        right = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive_step(4, 4, n, la, ra);
            exp = (k % 2 == 0) ? 3'b111 : 3'b000;
            checks++; if (bus0.l_lamp !== exp || bus0.r_lamp !== exp) begin
                failures++; $display("FAIL left_right_blink[%0d]: got l=%b r=%b, expected l=%b r=%b", k, bus0.l_lamp, bus0.r_lamp, exp, exp);
            end
        end
        left  = 1'b0;
        right = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [2:0] la;
        logic [2:0] ra;
        int n;
        left = 1'b1;
        for (int k = 0; k < 3; k++) drive_step(4, 4, n, la, ra);
        checks++; if (bus0.l_lamp !== 3'b111) begin
            failures++; $display("FAIL reach_l3: got l=%b, expected 111", bus0.l_lamp);
        end
        // Assert reset mid-cycle, well away from any clock edge.
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus0.l_lamp !== 3'b000 || bus0.r_lamp !== 3'b000) begin
            failures++; $display("FAIL async_reset: got l=%b r=%b before next edge, expected l=000 r=000", bus0.l_lamp, bus0.r_lamp);
        end
        checks++; if (bus1.l_lamp !== 3'b111 || bus1.r_lamp !== 3'b111) begin
            failures++; $display("FAIL async_reset_idle_on: got l=%b r=%b, expected l=111 r=111", bus1.l_lamp, bus1.r_lamp);
        end
        left = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_step(4, 4, n, la, ra);
            checks++; if (n !== 1 || bus0.l_lamp !== 3'b000 || bus0.r_lamp !== 3'b000) begin
                failures++; $display("FAIL no_resume[%0d]: got steps=%0d l=%b r=%b, expected steps=1 l=000 r=000", k, n, bus0.l_lamp, bus0.r_lamp);
            end
        end
    endtask

    task automatic test_idle_on();
        logic [2:0] la;
        logic [2:0] ra;
        int n;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus1.l_lamp !== 3'b111 || bus1.r_lamp !== 3'b111) begin
            failures++; $display("FAIL idle_on_park: got l=%b r=%b, expected l=111 r=111", bus1.l_lamp, bus1.r_lamp);
        end
        left = 1'b1;
        drive_step(4, 4, n, la, ra);
        checks++; if (bus1.l_lamp !== 3'b001 || bus1.r_lamp !== 3'b000) begin
            failures++; $display("FAIL idle_on_left1: got l=%b r=%b, expected l=001 r=000", bus1.l_lamp, bus1.r_lamp);
        end
        drive_step(4, 4, n, la, ra);
        checks++; if (bus1.l_lamp !== 3'b011 || bus1.r_lamp !== 3'b000) begin
            failures++; $display("FAIL idle_on_left2: got l=%b r=%b, expected l=011 r=000", bus1.l_lamp, bus1.r_lamp);
        end
        left = 1'b0;
    endtask

    initial begin
        test_reset();
        test_left();
        test_sampling();
        test_mid_change();
        test_left_right();
        test_async_reset();
        test_idle_on();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
